// File: rtl/multicycle_controller.sv
// Hardwired six-state multicycle control unit for the 16-bit RISC datapath.
// Optional build macro CTRL_ILLEGAL_TRAP_EN: illegal opcodes halt instead of acting as NOP.
module multicycle_controller #(
  parameter int OP_W = 5
) (
  input  logic       clk,
  input  logic       Rst,
  input  logic [7:0] InsM,
  input  logic [1:0] InsL,
  input  logic [2:0] PSW_NZC,
  output logic       ALUorNot,
  output logic       LIorMOV,
  output logic       MEMresource,
  output logic       WE_MEM,
  output logic       Buff_MEMIns,
  output logic       WBresource,
  output logic       RBresource,
  output logic       oprandB,
  output logic       LI,
  output logic       PCplus1orWB,
  output logic       WE_RF,
  output logic       Flag,
  output logic       ALUop,
  output logic       Buff_PSW,
  output logic       Branch,
  output logic [1:0] Jump,
  output logic       Buff_PC,
  output logic       done,
  output logic [2:0] state
);

  localparam logic [2:0] S_IF   = 3'd0;
  localparam logic [2:0] S_ID   = 3'd1;
  localparam logic [2:0] S_EX   = 3'd2;
  localparam logic [2:0] S_MEM  = 3'd3;
  localparam logic [2:0] S_WB   = 3'd4;
  localparam logic [2:0] S_HALT = 3'd5;

  localparam logic [OP_W-1:0] OPC_SYS   = OP_W'(0);
  localparam logic [OP_W-1:0] OPC_ALU   = OP_W'(1);
  localparam logic [OP_W-1:0] OPC_CMP   = OP_W'(2);
  localparam logic [OP_W-1:0] OPC_ADDI  = OP_W'(3);
  localparam logic [OP_W-1:0] OPC_SUBI  = OP_W'(4);
  localparam logic [OP_W-1:0] OPC_MOV   = OP_W'(5);
  localparam logic [OP_W-1:0] OPC_LLI   = OP_W'(6);
  localparam logic [OP_W-1:0] OPC_LHI   = OP_W'(7);
  localparam logic [OP_W-1:0] OPC_LDRRI = OP_W'(8);
  localparam logic [OP_W-1:0] OPC_LDRRR = OP_W'(9);
  localparam logic [OP_W-1:0] OPC_STRRI = OP_W'(10);
  localparam logic [OP_W-1:0] OPC_STRRR = OP_W'(11);
  localparam logic [OP_W-1:0] OPC_BCC   = OP_W'(12);
  localparam logic [OP_W-1:0] OPC_JMP   = OP_W'(13);
  localparam logic [OP_W-1:0] OPC_JALRL = OP_W'(14);
  localparam logic [OP_W-1:0] OPC_JALRR = OP_W'(15);
  localparam logic [OP_W-1:0] OPC_JR    = OP_W'(16);

  logic [2:0]      state_q, state_d;
  logic [OP_W-1:0] op;
  logic [2:0]      cond;
  logic            flag_c, flag_z, unused_flag_n;
  logic            is_alu, is_imm, is_ld_imm, is_ldr, is_str, taken;

  assign op            = InsM[7 -: OP_W];
  assign cond          = InsM[2:0];
  assign flag_c        = PSW_NZC[0];
  assign flag_z        = PSW_NZC[1];
  assign unused_flag_n = PSW_NZC[2];

  assign is_alu    = (op == OPC_ALU);
  assign is_imm    = (op == OPC_ADDI) || (op == OPC_SUBI);
  assign is_ld_imm = (op == OPC_MOV) || (op == OPC_LLI) || (op == OPC_LHI);
  assign is_ldr    = (op == OPC_LDRRI) || (op == OPC_LDRRR);
  assign is_str    = (op == OPC_STRRI) || (op == OPC_STRRR);

  always_comb begin
    taken = 1'b0;
    case (cond)
      3'd0:    taken = ~flag_c;
      3'd1:    taken = flag_c;
      3'd2:    taken = ~flag_z;
      3'd3:    taken = flag_z;
      3'd4:    taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge Rst) begin
    if (Rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Strobes are built ungated here; reset forces every output low below.
  logic       c_aluornot, c_liormov, c_memres, c_wemem, c_memins, c_wbres;
  logic       c_rbres, c_oprb, c_li, c_pc1wb, c_werf, c_flag, c_aluop;
  logic       c_psw, c_branch, c_bpc, c_done;
  logic [1:0] c_jump;

  always_comb begin
    state_d    = state_q;
    c_aluornot = 1'b0; c_liormov = 1'b0; c_memres = 1'b0; c_wemem = 1'b0;
    c_memins   = 1'b0; c_wbres   = 1'b0; c_rbres  = 1'b0; c_oprb  = 1'b0;
    c_li       = 1'b0; c_pc1wb   = 1'b0; c_werf   = 1'b0; c_flag  = 1'b0;
    c_aluop    = 1'b0; c_psw     = 1'b0; c_branch = 1'b0; c_jump  = 2'b00;
    c_bpc      = 1'b0; c_done    = 1'b0;
    case (state_q)
      S_IF: begin
        c_memins = 1'b1;
        state_d  = S_ID;
      end
      S_ID: begin
        state_d = S_IF;
        case (op)
          OPC_SYS: begin
            c_bpc = 1'b1;
            if (InsL == 2'b01) state_d = S_HALT;
          end
          OPC_ALU, OPC_CMP:     state_d = S_EX;
          OPC_ADDI, OPC_SUBI: begin c_oprb = 1'b1; state_d = S_EX; end
          OPC_MOV, OPC_LLI:   begin c_rbres = 1'b1; state_d = S_EX; end
          OPC_LHI: begin c_rbres = 1'b1; c_li = 1'b1; state_d = S_EX; end
          OPC_LDRRI, OPC_STRRI: begin c_oprb = 1'b1; state_d = S_EX; end
          OPC_LDRRR, OPC_STRRR: state_d = S_EX;
          OPC_BCC:   begin c_branch = taken; c_bpc = 1'b1; end
          OPC_JMP:   begin c_jump = 2'b01; c_bpc = 1'b1; end
          OPC_JALRL: begin c_branch = 1'b1; c_werf = 1'b1; c_bpc = 1'b1; end
          OPC_JALRR: begin c_jump = 2'b10; c_werf = 1'b1; c_bpc = 1'b1; end
          OPC_JR:    begin c_rbres = 1'b1; c_jump = 2'b11; c_bpc = 1'b1; end
          default: begin
`ifdef CTRL_ILLEGAL_TRAP_EN
            state_d = S_HALT;
`else
            c_bpc = 1'b1;
`endif
          end
        endcase
      end
      S_EX: begin
        state_d = S_MEM;
        if (is_alu) begin
          c_flag  = InsL[0];
          c_aluop = InsL[1];
          c_psw   = 1'b1;
        end else if (is_imm) begin
          c_aluop = (op == OPC_SUBI);
          c_psw   = 1'b1;
        end else if (op == OPC_CMP) begin
          c_aluop = 1'b1;
          c_psw   = 1'b1;
          c_bpc   = 1'b1;
          state_d = S_IF;
        end else if (is_str) begin
          c_rbres = 1'b1;
        end
      end
      S_MEM: begin
        state_d = S_WB;
        if (is_ld_imm) begin
          c_aluornot = 1'b1;
          c_liormov  = (op == OPC_MOV);
        end else if (is_ldr) begin
          c_memres = 1'b1;
        end else if (is_str) begin
          c_memres = 1'b1;
          c_wemem  = 1'b1;
          c_bpc    = 1'b1;
          state_d  = S_IF;
        end
      end
      S_WB: begin
        state_d = S_IF;
        c_werf  = 1'b1;
        c_bpc   = 1'b1;
        c_wbres = is_ldr;
        c_pc1wb = ~is_ldr;
      end
      S_HALT: c_done = 1'b1;
      default: state_d = S_IF;
    endcase
  end

  assign ALUorNot    = c_aluornot & ~Rst;
  assign LIorMOV     = c_liormov  & ~Rst;
  assign MEMresource = c_memres   & ~Rst;
  assign WE_MEM      = c_wemem    & ~Rst;
  assign Buff_MEMIns = c_memins   & ~Rst;
  assign WBresource  = c_wbres    & ~Rst;
  assign RBresource  = c_rbres    & ~Rst;
  assign oprandB     = c_oprb     & ~Rst;
  assign LI          = c_li       & ~Rst;
  assign PCplus1orWB = c_pc1wb    & ~Rst;
  assign WE_RF       = c_werf     & ~Rst;
  assign Flag        = c_flag     & ~Rst;
  assign ALUop       = c_aluop    & ~Rst;
  assign Buff_PSW    = c_psw      & ~Rst;
  assign Branch      = c_branch   & ~Rst;
  assign Jump        = c_jump     & {2{~Rst}};
  assign Buff_PC     = c_bpc      & ~Rst;
  assign done        = c_done     & ~Rst;
  assign state       = state_q    & {3{~Rst}};

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomized bench for multicycle_controller: per-cycle expected state and
// strobe vectors are derived from the instruction rules and queued in exp_q.
module tb_multicycle_controller;

  logic       clk, Rst;
  logic [7:0] InsM;
  logic [1:0] InsL;
  logic [2:0] PSW_NZC;
  logic       ALUorNot, LIorMOV, MEMresource, WE_MEM, Buff_MEMIns, WBresource;
  logic       RBresource, oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop;
  logic       Buff_PSW, Branch, Buff_PC, done;
  logic [1:0] Jump;
  logic [2:0] state;

  multicycle_controller #(.OP_W(5)) dut (
    .clk(clk), .Rst(Rst), .InsM(InsM), .InsL(InsL), .PSW_NZC(PSW_NZC),
    .ALUorNot(ALUorNot), .LIorMOV(LIorMOV), .MEMresource(MEMresource),
    .WE_MEM(WE_MEM), .Buff_MEMIns(Buff_MEMIns), .WBresource(WBresource),
    .RBresource(RBresource), .oprandB(oprandB), .LI(LI),
    .PCplus1orWB(PCplus1orWB), .WE_RF(WE_RF), .Flag(Flag), .ALUop(ALUop),
    .Buff_PSW(Buff_PSW), .Branch(Branch), .Jump(Jump), .Buff_PC(Buff_PC),
    .done(done), .state(state)
  );

  // Observed strobes packed as {ALUorNot .. done}, 19 bits.
  logic [18:0] obs;
  assign obs = {ALUorNot, LIorMOV, MEMresource, WE_MEM, Buff_MEMIns, WBresource,
                RBresource, oprandB, LI, PCplus1orWB, WE_RF, Flag, ALUop,
                Buff_PSW, Branch, Jump, Buff_PC, done};

  localparam logic [18:0] M_ALUORNOT = 19'h1 << 18;
  localparam logic [18:0] M_LIORMOV  = 19'h1 << 17;
  localparam logic [18:0] M_MEMRES   = 19'h1 << 16;
  localparam logic [18:0] M_WEMEM    = 19'h1 << 15;
  localparam logic [18:0] M_FETCH    = 19'h1 << 14;
  localparam logic [18:0] M_WBRES    = 19'h1 << 13;
  localparam logic [18:0] M_RBRES    = 19'h1 << 12;
  localparam logic [18:0] M_OPRB     = 19'h1 << 11;
  localparam logic [18:0] M_LI       = 19'h1 << 10;
  localparam logic [18:0] M_PC1WB    = 19'h1 << 9;
  localparam logic [18:0] M_WERF     = 19'h1 << 8;
  localparam logic [18:0] M_FLAG     = 19'h1 << 7;
  localparam logic [18:0] M_ALUOP    = 19'h1 << 6;
  localparam logic [18:0] M_PSW      = 19'h1 << 5;
  localparam logic [18:0] M_BRANCH   = 19'h1 << 4;
  localparam logic [18:0] M_J01      = 19'h1 << 2;
  localparam logic [18:0] M_J10      = 19'h2 << 2;
  localparam logic [18:0] M_J11      = 19'h3 << 2;
  localparam logic [18:0] M_PC       = 19'h1 << 1;
  localparam logic [18:0] M_DONE     = 19'h1;

  logic [21:0] exp_q[$];
  int n_checks = 0;
  int n_errors = 0;

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  // Enter at posedge+1, leave at posedge+1 with the DUT in its first IF cycle.
  task automatic do_reset();
    Rst = 1'b1;
    @(negedge clk);
    check_eq("rst.state", 32'(state), 32'd0);
    check_eq("rst.ctl", 32'(obs), 32'd0);
    @(posedge clk); #1;
    check_eq("rst.hold", 32'(obs), 32'd0);
    Rst = 1'b0;
  endtask

  // ---------------- reference model ----------------
  task automatic push(input logic [2:0] st, input logic [18:0] v);
    exp_q.push_back({st, v});
  endtask

  task automatic model_instr(input logic [4:0] op, input logic [2:0] cnd,
                             input logic [1:0] fn, input logic [2:0] fl,
                             output bit halts);
    bit tk;
    halts = 1'b0;
    push(3'd0, M_FETCH);
    case (cnd)
      3'd0: tk = !fl[0];
      3'd1: tk = fl[0];
      3'd2: tk = !fl[1];
      3'd3: tk = fl[1];
      3'd4: tk = 1'b1;
      default: tk = 1'b0;
    endcase
    if (op == 0) begin
      push(3'd1, M_PC);
      halts = (fn == 2'b01);
    end else if (op == 1 || op == 3 || op == 4) begin
      push(3'd1, (op == 1) ? 19'h0 : M_OPRB);
      if (op == 1) push(3'd2, (fn[0] ? M_FLAG : 19'h0) | (fn[1] ? M_ALUOP : 19'h0) | M_PSW);
      else         push(3'd2, ((op == 4) ? M_ALUOP : 19'h0) | M_PSW);
      push(3'd3, 19'h0);
      push(3'd4, M_PC1WB | M_WERF | M_PC);
    end else if (op == 2) begin
      push(3'd1, 19'h0);
      push(3'd2, M_ALUOP | M_PSW | M_PC);
    end else if (op >= 5 && op <= 7) begin
      push(3'd1, M_RBRES | ((op == 7) ? M_LI : 19'h0));
      push(3'd2, 19'h0);
      push(3'd3, M_ALUORNOT | ((op == 5) ? M_LIORMOV : 19'h0));
      push(3'd4, M_PC1WB | M_WERF | M_PC);
    end else if (op == 8 || op == 9) begin
      push(3'd1, (op == 8) ? M_OPRB : 19'h0);
      push(3'd2, 19'h0);
      push(3'd3, M_MEMRES);
      push(3'd4, M_WBRES | M_WERF | M_PC);
    end else if (op == 10 || op == 11) begin
      push(3'd1, (op == 10) ? M_OPRB : 19'h0);
      push(3'd2, M_RBRES);
      push(3'd3, M_MEMRES | M_WEMEM | M_PC);
    end else if (op == 12) push(3'd1, (tk ? M_BRANCH : 19'h0) | M_PC);
    else if (op == 13) push(3'd1, M_J01 | M_PC);
    else if (op == 14) push(3'd1, M_BRANCH | M_WERF | M_PC);
    else if (op == 15) push(3'd1, M_J10 | M_WERF | M_PC);
    else if (op == 16) push(3'd1, M_RBRES | M_J11 | M_PC);
    else begin
`ifdef CTRL_ILLEGAL_TRAP_EN
      push(3'd1, 19'h0);
      halts = 1'b1;
`else
      push(3'd1, M_PC);
`endif
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_instr(input logic [4:0] op, input logic [2:0] cnd,
                           input logic [1:0] fn, input logic [2:0] fl,
                           output bit halts);
    logic [21:0] e;
    int k;
    InsM = {op, cnd};
    InsL = fn;
    PSW_NZC = fl;
    model_instr(op, cnd, fn, fl, halts);
    k = 0;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      @(negedge clk);
      check_eq($sformatf("op%0d.c%0d.state", op, k), 32'(state), 32'(e[21:19]));
      check_eq($sformatf("op%0d.c%0d.ctl", op, k), 32'(obs), 32'(e[18:0]));
      @(posedge clk); #1;
      k++;
    end
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_eq("halt.state", 32'(state), 32'd5);
      check_eq("halt.ctl", 32'(obs), 32'(M_DONE));
      @(posedge clk); #1;
    end
  endtask

  task automatic run_and_recover(input logic [4:0] op, input logic [2:0] cnd,
                                 input logic [1:0] fn, input logic [2:0] fl);
    bit h;
    run_instr(op, cnd, fn, fl, h);
    if (h) begin
      halt_cycles(3);
      do_reset();
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit h;
    logic [4:0] op;
    logic [1:0] fn;
    Rst = 1'b1; InsM = 8'h00; InsL = 2'b00; PSW_NZC = 3'b000;
    @(posedge clk); #1;
    do_reset();

    run_and_recover(5'd6, 3'd0, 2'b10, 3'b000);          // LLI R0,0x0A
    run_and_recover(5'd6, 3'd1, 2'b01, 3'b000);          // LLI R1,0x05
    for (int f = 0; f < 4; f++)
      run_and_recover(5'd1, 3'd2, 2'(f), 3'($urandom_range(0, 7)));
    run_and_recover(5'd2, 3'd0, 2'b00, 3'b000);          // CMP
    run_and_recover(5'd12, 3'd3, 2'b00, 3'b010);         // BEQ, Z=1
    run_and_recover(5'd12, 3'd3, 2'b00, 3'b101);         // BEQ, Z=0
    run_and_recover(5'd10, 3'd4, 2'b11, 3'b000);         // STRri
    run_and_recover(5'd5, 3'd1, 2'b00, 3'b000);          // MOV
    run_and_recover(5'd7, 3'd1, 2'b00, 3'b000);          // LHI

    for (int n = 0; n < 150; n++) begin
      int r;
      r = $urandom_range(0, 19);
      op = (r <= 16) ? 5'(r) : 5'($urandom_range(17, 31));
      fn = 2'($urandom_range(0, 3));
      if (op == 5'd3 || op == 5'd4) fn[0] = 1'b0;
      run_and_recover(op, 3'($urandom_range(0, 7)), fn, 3'($urandom_range(0, 7)));
    end

    run_and_recover(5'd31, 3'd0, 2'b00, 3'b000);         // illegal opcode

    // Reset during EX of ADD: no writeback strobe may appear.
    InsM = {5'd1, 3'd0}; InsL = 2'b00; PSW_NZC = 3'b000;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check_eq("abort.state", 32'(state), 32'(c));
      if (c < 2) begin @(posedge clk); #1; end
    end
    #1 Rst = 1'b1;
    #1 check_eq("abort.werf", 32'(WE_RF), 32'd0);
    check_eq("abort.ctl", 32'(obs), 32'd0);
    @(posedge clk); #1;
    check_eq("abort.hold", 32'(obs), 32'd0);
    Rst = 1'b0;
    run_and_recover(5'd6, 3'd2, 2'b11, 3'b000);

    run_instr(5'd0, 3'd0, 2'b01, 3'b000, h);             // HLT
    check_eq("hlt.flag", 32'(h), 32'd1);
    halt_cycles(20);
    do_reset();
    run_and_recover(5'd0, 3'd0, 2'b10, 3'b000);          // NOP after reset

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
